booth_arbiter: RTL and testbench

BOOTH_ARBITER -- requirements
Module: booth_arbiter

---
 rtl/booth_arbiter_pkg.sv | 28 ++
 rtl/booth_arbiter_seq_core.sv | 74 +++++++
 rtl/booth_arbiter.sv | 118 +++++++++++
 tb/tb_booth_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_arbiter_pkg.sv
// Shared types for the round-robin Booth multiplier arbiter.
// Holds the FSM state encoding and the Booth step opcodes.
package booth_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } op_e;

    // Booth recoding of the (q0, q-1) pair.
    function automatic op_e booth_op(input logic [1:0] pair);
        op_e op;
        case (pair)
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_arbiter_seq_core.sv
// Sequential radix-2 Booth multiplier, one step per clock.
// Ports: clk, rst_n (async low), start_i, a_i, b_i in;
//        done_o (counter at zero), product_o (signed a*b) out.
module booth_seq_core
    import booth_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int AW = 2 * WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    // acc = {upper (WIDTH+1, sign guard), multiplier (WIDTH), q-1}
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   upper;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   sum;
    logic [AW-1:0]    shifted;
    op_e              op;

    always_comb begin
        upper = acc_q[AW-1 -: WIDTH+1];
        a_ext = {a_q[WIDTH-1], a_q};
        op    = booth_op(acc_q[1:0]);
        case (op)
            OP_ADD:  sum = upper + a_ext;
            OP_SUB:  sum = upper - a_ext;
            default: sum = upper;
        endcase
        // arithmetic shift right of {sum, multiplier, q-1}
        shifted = {sum[WIDTH], sum, acc_q[WIDTH:1]};
    end

    always_comb begin
        acc_d = acc_q;
        a_d   = a_q;
        cnt_d = cnt_q;
        if (start_i) begin
            acc_d = {{(WIDTH + 1){1'b0}}, b_i, 1'b0};
            a_d   = a_i;
            cnt_d = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_d = shifted;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            a_q   <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            a_q   <= a_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o    = (cnt_q == '0);
    assign product_o = acc_q[2*WIDTH:1];

endmodule

// File: rtl/booth_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier.
// Ports: clk, rst (async low); req_valid/req_a/req_b/req_ready per
//        requester; rsp_valid/rsp_ready/rsp_id/rsp_c response; busy.
module booth_arbiter
    import booth_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [2*WIDTH-1:0]      rsp_c,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   id_q, id_d;

    logic             found;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   cand;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             hs;
    logic             core_done;
    logic [2*WIDTH-1:0] core_prod;

    // Search starts one past the last granted requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(last_q) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grants are suppressed while reset is held.
    assign hs        = rst && (state_q == S_IDLE) && found;
    assign req_ready = hs ? (NREQ'(1) << win) : '0;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    state_d = S_RUN;
                    last_d  = win;
                    id_d    = win;
                end
            end
            S_RUN: begin
                if (core_done) state_d = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
        end
    end

    booth_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst),
        .start_i   (hs),
        .a_i       (a_sel),
        .b_i       (b_sel),
        .done_o    (core_done),
        .product_o (core_prod)
    );

    assign rsp_valid = (state_q == S_DONE);
    assign rsp_c     = rsp_valid ? core_prod : '0;
    assign rsp_id    = rsp_valid ? id_q : '0;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_booth_arbiter.sv
// Self-checking bench for booth_arbiter: directed corners plus a
// scoreboarded random run with a signed reference product.
module tb_booth_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    typedef struct {
        int          id;
        logic [63:0] c;
    } sb_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [63:0]           rsp_c;
    logic                  busy;

    int  errs   = 0;
    int  checks = 0;
    sb_t sb[$];
    int  gnt_log[$];
    int  done_cnt = 0;
    int  waitc[NREQ];
    logic [NREQ-1:0] hs_neg = '0;

    booth_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a,
                                         input logic [31:0] b);
        logic [63:0] a64;
        logic [63:0] b64;
        a64 = {{32{a[31]}}, a};
        b64 = {{32{b[31]}}, b};
        return a64 * b64;
    endfunction

    function automatic logic [31:0] pick();
        int r;
        r = int'($urandom_range(0, 7));
        case (r)
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: handshakes push the model result, accepts pop it.
    int          mw;
    logic [31:0] ma, mb;
    sb_t         ent;
    always @(negedge clk) begin
        hs_neg = req_valid & req_ready;
        for (int j = 0; j < NREQ; j++)
            if (!req_valid[j]) waitc[j] = 0;
        if (req_ready != '0)
            check("onehot", 64'($countones(req_ready)), 64'd1);
        if (hs_neg != '0) begin
            mw = 0;
            for (int j = 0; j < NREQ; j++)
                if (hs_neg[j]) mw = j;
            check("starve", 64'(waitc[mw] < NREQ), 64'd1);
            for (int j = 0; j < NREQ; j++)
                if (j != mw && req_valid[j]) waitc[j]++;
            waitc[mw] = 0;
            ma = req_a[mw*WIDTH +: WIDTH];
            mb = req_b[mw*WIDTH +: WIDTH];
            ent.id = mw;
            ent.c  = smul(ma, mb);
            sb.push_back(ent);
            gnt_log.push_back(mw);
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("sb_empty", 64'd1, 64'd0);
            end else begin
                ent = sb.pop_front();
                check("rsp_c", rsp_c, ent.c);
                check("rsp_id", 64'(rsp_id), 64'(ent.id));
            end
            done_cnt++;
        end
    end

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 64'(n < 200), 64'd1);
    endtask

    task automatic issue(input int id, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
        int n;
        drain("idle_wait");
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_valid = NREQ'(1) << id;
        #1;
        check("grant", 64'(req_ready), 64'(NREQ'(1) << id));
        @(posedge clk); #1;
        req_valid = '0;
        req_a[id*WIDTH +: WIDTH] = ~a;
        req_b[id*WIDTH +: WIDTH] = a ^ b;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'd33);
        check("prod", rsp_c, exp);
        check("id", 64'(rsp_id), 64'(id));
        @(posedge clk); #1;
        check("rsp_drop", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        int go[5];
        int g0;
        logic [63:0] exp;
        go = '{0, 1, 2, 3, 0};
        for (int j = 0; j < NREQ; j++) waitc[j] = 0;

        rst       = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        for (int j = 0; j < NREQ; j++) begin
            req_a[j*WIDTH +: WIDTH] = 32'(j + 2);
            req_b[j*WIDTH +: WIDTH] = 32'(-(j + 5));
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_c", rsp_c, 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);

        // all requesters valid from release
        rst = 1'b1;
        n = 0;
        while (gnt_log.size() < 5 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        req_valid = '0;
        check("go_bound", 64'(n < 300), 64'd1);
        drain("go_drain");
        if (gnt_log.size() >= 5)
            for (int k = 0; k < 5; k++)
                check("gnt_order", 64'(gnt_log[k]), 64'(go[k]));

        issue(0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        issue(2, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        issue(3, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
        issue(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);

        // consumer stall in DONE
        drain("st_idle");
        rsp_ready = 1'b0;
        exp = smul(32'h1234_5678, 32'h9ABC_DEF0);
        req_a[1*WIDTH +: WIDTH] = 32'h1234_5678;
        req_b[1*WIDTH +: WIDTH] = 32'h9ABC_DEF0;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("st_lat", 64'(n), 64'd33);
        g0 = gnt_log.size();
        repeat (10) begin
            @(posedge clk); #1;
            check("st_valid", 64'(rsp_valid), 64'd1);
            check("st_c", rsp_c, exp);
            check("st_id", 64'(rsp_id), 64'd1);
            check("st_ready", 64'(req_ready), 64'd0);
        end
        check("st_nogrant", 64'(gnt_log.size()), 64'(g0));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("st_rel", 64'(rsp_valid), 64'd0);
        check("st_next", 64'(req_ready), 64'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        check("st_grant", 64'(gnt_log.size()), 64'(g0 + 1));
        drain("st_drain");

        // reset in the middle of RUN
        req_a[3*WIDTH +: WIDTH] = 32'd11;
        req_b[3*WIDTH +: WIDTH] = 32'd13;
        req_valid = 4'b1000;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mr_valid", 64'(rsp_valid), 64'd0);
        check("mr_c", rsp_c, 64'd0);
        check("mr_id", 64'(rsp_id), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_ready", 64'(req_ready), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rsp_valid || busy) cnt++;
        end
        check("mr_stale", 64'(cnt), 64'd0);
        req_valid = '1;
        #1;
        check("mr_first", 64'(req_ready), 64'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        drain("mr_drain");

        // random traffic with sticky valids
        done_cnt = 0;
        n = 0;
        while (done_cnt < 300 && n < 40000) begin
            @(posedge clk); #1;
            n++;
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int j = 0; j < NREQ; j++) begin
                if (hs_neg[j]) req_valid[j] = 1'b0;
                if (!req_valid[j] && $urandom_range(0, 3) == 0) begin
                    req_a[j*WIDTH +: WIDTH] = pick();
                    req_b[j*WIDTH +: WIDTH] = pick();
                    req_valid[j] = 1'b1;
                end
            end
        end
        check("rnd_bound", 64'(n < 40000), 64'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        drain("rnd_drain");
        check("sb_left", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
